lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port_if.sv | 37 +++
 rtl/lsu_mem_port.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mem_port_if : request/response and data-memory bus of the LSU    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lsu_mem_port_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [3:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [4:0]            req_rd;
   logic                  resp_valid;
   logic [31:0]           resp_data;
   logic [4:0]            resp_rd;
   logic                  exc_misalign;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_data;
   logic                  mem_we;
   logic [31:0]           mem_rdata;

   // master: execute stage plus data memory; slave: the load/store unit
   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_rd, exc_misalign,
             mem_addr, mem_data, mem_we
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_rd, exc_misalign,
             mem_addr, mem_data, mem_we
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mem_port : load/store initiator to a word-addressed data memory  |
// | Optional macro LSU_MISALIGN_EXC_EN: trap misaligned accesses.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_mem_port #(
   parameter int ADDR_WIDTH = 32
) (
   input  wire logic      clk,
   input  wire logic      rst,
   lsu_mem_port_if.slave  bus
);

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_SB  = 4'd5;
   localparam logic [3:0] OP_SH  = 4'd6;
   localparam logic [3:0] OP_SW  = 4'd7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [4:0]            rd_q;
   logic [31:0]           merge_q, merge_d;
   logic                  resp_valid_q;
   logic [31:0]           resp_data_q;
   logic [4:0]            resp_rd_q;
   logic                  accept;
   logic                  trap;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic [31:0]           byte_shift, half_shift, load_ext;

   assign bus.req_ready = (state_q == IDLE) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_EXC_EN
   logic misalign;
   logic exc_q;

   always_comb begin
      misalign = 1'b0;
      case (bus.req_op)
         OP_LH, OP_LHU, OP_SH: misalign = bus.req_addr[0];
         OP_LW, OP_SW:         misalign = |bus.req_addr[1:0];
         default:              misalign = 1'b0;
      endcase
   end

   assign trap    = misalign;
   assign addr_in = bus.req_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) exc_q <= 1'b0;
      else     exc_q <= accept && misalign;
   end
   assign bus.exc_misalign = exc_q;
`else
   // Misaligned accesses are silently rounded down to the access size.
   always_comb begin
      addr_in = bus.req_addr;
      case (bus.req_op)
         OP_LH, OP_LHU, OP_SH: addr_in[0]   = 1'b0;
         OP_LW, OP_SW:         addr_in[1:0] = 2'b00;
         default:              addr_in      = bus.req_addr;
      endcase
   end

   assign trap             = 1'b0;
   assign bus.exc_misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && !trap) begin
               case (bus.req_op)
                  OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: state_d = LOAD;
                  OP_SW:                               state_d = STORE;
                  OP_SB, OP_SH:                        state_d = RMW_RD;
                  default:                             state_d = IDLE;
               endcase
            end
         end
         LOAD:    state_d = IDLE;
         STORE:   state_d = IDLE;
         RMW_RD:  state_d = RMW_WR;
         RMW_WR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write strobe and data come from state alone so request inputs never glitch the bus.
   assign bus.mem_we   = (state_q == STORE) || (state_q == RMW_WR);
   assign bus.mem_data = (state_q == STORE)  ? wdata_q :
                         (state_q == RMW_WR) ? merge_q : 32'd0;
   assign bus.mem_addr = addr_q;

   assign byte_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
   assign half_shift = bus.mem_rdata >> {addr_q[1], 4'b0000};

   always_comb begin
      load_ext = bus.mem_rdata;
      case (op_q)
         OP_LB:   load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
         OP_LBU:  load_ext = {24'd0, byte_shift[7:0]};
         OP_LH:   load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
         OP_LHU:  load_ext = {16'd0, half_shift[15:0]};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   always_comb begin
      merge_d = bus.mem_rdata;
      if (op_q == OP_SB) merge_d[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      else               merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= 4'd0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         rd_q         <= 5'd0;
         merge_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'd0;
         resp_rd_q    <= 5'd0;
      end else begin
         resp_valid_q <= (state_q == LOAD);
         if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= addr_in;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
         end
         if (state_q == LOAD) begin
            resp_data_q <= load_ext;
            resp_rd_q   <= rd_q;
         end
         if (state_q == RMW_RD) merge_q <= merge_d;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_rd    = resp_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_mem_port : directed self-checking bench for lsu_mem_port      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lsu_mem_port;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   failures;
   int   rv_tot, we_tot, ex_tot;
   logic [31:0] last_data;
   logic [31:0] mem [0:63];

   lsu_mem_port_if #(.ADDR_WIDTH(32)) bus ();

   lsu_mem_port #(.ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_data;

   initial begin
      rv_tot = 0;
      we_tot = 0;
      ex_tot = 0;
   end
   always @(negedge clk) begin
      if (bus.resp_valid)   rv_tot = rv_tot + 1;
      if (bus.mem_we)       we_tot = we_tot + 1;
      if (bus.exc_misalign) ex_tot = ex_tot + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_req(input int idx, input vec_t v);
      int  n;
      int  rv0, we0, ex0;
      bit  is_load, is_store;
      is_load  = (v.op <= 4'd4);
      is_store = (v.op >= 4'd5) && (v.op <= 4'd7);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      check($sformatf("v%0d ready", idx), {31'd0, bus.req_ready}, 32'd1);
      rv0 = rv_tot; we0 = we_tot; ex0 = ex_tot;
      bus.req_op    = v.op;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_rd    = v.rd;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check($sformatf("v%0d rv_n1", idx), {31'd0, bus.resp_valid}, 32'd0);
      check($sformatf("v%0d we_n1", idx), {31'd0, bus.mem_we}, {31'd0, v.op == 4'd7});
      @(posedge clk); #1;
      if (is_load) begin
         check($sformatf("v%0d rv_n2", idx), {31'd0, bus.resp_valid}, 32'd1);
         check($sformatf("v%0d data", idx), bus.resp_data, v.exp);
         check($sformatf("v%0d rd", idx), {27'd0, bus.resp_rd}, {27'd0, v.rd});
         last_data = v.exp;
      end else begin
         check($sformatf("v%0d we_n2", idx), {31'd0, bus.mem_we},
               {31'd0, (v.op == 4'd5) || (v.op == 4'd6)});
      end
      repeat (2) begin @(posedge clk); #1; end
      check($sformatf("v%0d rv_cnt", idx), rv_tot - rv0, is_load ? 32'd1 : 32'd0);
      check($sformatf("v%0d we_cnt", idx), we_tot - we0, is_store ? 32'd1 : 32'd0);
      check($sformatf("v%0d exc_cnt", idx), ex_tot - ex0, 32'd0);
      check($sformatf("v%0d hold", idx), bus.resp_data, last_data);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [0:19];
      vec_t v;
      int   rv0, we0, ex0;
      vecs[0]  = '{4'd7, 32'h10, 32'hDEADBEEF, 5'd0,  32'h0};
      vecs[1]  = '{4'd4, 32'h10, 32'h0,        5'd5,  32'hDEADBEEF};
      vecs[2]  = '{4'd7, 32'h20, 32'h11223344, 5'd0,  32'h0};
      vecs[3]  = '{4'd5, 32'h22, 32'h000000AA, 5'd0,  32'h0};
      vecs[4]  = '{4'd4, 32'h20, 32'h0,        5'd1,  32'h11AA3344};
      vecs[5]  = '{4'd0, 32'h22, 32'h0,        5'd7,  32'hFFFFFFAA};
      vecs[6]  = '{4'd1, 32'h22, 32'h0,        5'd8,  32'h000000AA};
      vecs[7]  = '{4'd7, 32'h24, 32'h00000000, 5'd0,  32'h0};
      vecs[8]  = '{4'd6, 32'h26, 32'h12348001, 5'd0,  32'h0};
      vecs[9]  = '{4'd4, 32'h24, 32'h0,        5'd2,  32'h80010000};
      vecs[10] = '{4'd2, 32'h26, 32'h0,        5'd3,  32'hFFFF8001};
      vecs[11] = '{4'd3, 32'h26, 32'h0,        5'd4,  32'h00008001};
      vecs[12] = '{4'd0, 32'h21, 32'h0,        5'd9,  32'h00000033};
      vecs[13] = '{4'd0, 32'h23, 32'h0,        5'd10, 32'h00000011};
      vecs[14] = '{4'd2, 32'h20, 32'h0,        5'd11, 32'h00003344};
      vecs[15] = '{4'd2, 32'h22, 32'h0,        5'd12, 32'h000011AA};
      vecs[16] = '{4'd5, 32'h20, 32'hFFFFFF80, 5'd0,  32'h0};
      vecs[17] = '{4'd4, 32'h20, 32'h0,        5'd13, 32'h11AA3380};
      vecs[18] = '{4'd9, 32'h20, 32'hFFFFFFFF, 5'd14, 32'h0};
      vecs[19] = '{4'd4, 32'h20, 32'h0,        5'd31, 32'h11AA3380};

      tests = 0; failures = 0; last_data = 32'd0;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_addr = 32'd0;
      bus.req_wdata = 32'd0; bus.req_rd = 5'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst ready",      {31'd0, bus.req_ready},    32'd0);
      check("rst resp_valid", {31'd0, bus.resp_valid},   32'd0);
      check("rst resp_data",  bus.resp_data,             32'd0);
      check("rst resp_rd",    {27'd0, bus.resp_rd},      32'd0);
      check("rst exc",        {31'd0, bus.exc_misalign}, 32'd0);
      check("rst mem_we",     {31'd0, bus.mem_we},       32'd0);
      check("rst mem_data",   bus.mem_data,              32'd0);
      check("rst mem_addr",   bus.mem_addr,              32'd0);
      rst = 1'b0;
      #1;
      check("post-rst ready", {31'd0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 20; i++) run_req(i, vecs[i]);

      // Back-to-back: req_valid held high across a load and a following store.
      rv0 = rv_tot; we0 = we_tot;
      bus.req_op = 4'd4; bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_rd = 5'd3;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b ready_load", {31'd0, bus.req_ready}, 32'd0);
      bus.req_op = 4'd7; bus.req_addr = 32'h28; bus.req_wdata = 32'h5A5A5A5A; bus.req_rd = 5'd0;
      @(posedge clk); #1;
      check("b2b ready_idle", {31'd0, bus.req_ready}, 32'd1);
      check("b2b rv",         {31'd0, bus.resp_valid}, 32'd1);
      check("b2b data",       bus.resp_data, 32'hDEADBEEF);
      check("b2b rd",         {27'd0, bus.resp_rd}, 32'd3);
      last_data = 32'hDEADBEEF;
      @(posedge clk); #1;
      check("b2b we_store",    {31'd0, bus.mem_we}, 32'd1);
      check("b2b ready_store", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("b2b rv_cnt", rv_tot - rv0, 32'd1);
      check("b2b we_cnt", we_tot - we0, 32'd1);
      v = '{4'd4, 32'h28, 32'h0, 5'd6, 32'h5A5A5A5A};
      run_req(20, v);

      // Reset while the RMW write of an SB is on the bus.
      v = '{4'd7, 32'h30, 32'hCAFEBABE, 5'd0, 32'h0};
      run_req(21, v);
      rv0 = rv_tot;
      bus.req_op = 4'd5; bus.req_addr = 32'h30; bus.req_wdata = 32'h55; bus.req_rd = 5'd0;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("rmw we_rd", {31'd0, bus.mem_we}, 32'd0);
      @(posedge clk); #1;
      check("rmw we_wr", {31'd0, bus.mem_we}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rmw we_async", {31'd0, bus.mem_we}, 32'd0);
      check("rmw ready_rst", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rmw ready_rel", {31'd0, bus.req_ready}, 32'd1);
      check("rmw mem", mem[12], 32'hCAFEBABE);
      check("rmw rv_cnt", rv_tot - rv0, 32'd0);
      last_data = 32'd0;
      v = '{4'd4, 32'h30, 32'h0, 5'd15, 32'hCAFEBABE};
      run_req(22, v);

`ifdef LSU_MISALIGN_EXC_EN
      rv0 = rv_tot; we0 = we_tot; ex0 = ex_tot;
      bus.req_op = 4'd4; bus.req_addr = 32'h13; bus.req_wdata = 32'h0; bus.req_rd = 5'd9;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("mis exc_n1",   {31'd0, bus.exc_misalign}, 32'd1);
      check("mis ready_n1", {31'd0, bus.req_ready}, 32'd1);
      check("mis we_n1",    {31'd0, bus.mem_we}, 32'd0);
      @(posedge clk); #1;
      check("mis exc_n2", {31'd0, bus.exc_misalign}, 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      check("mis rv_cnt",  rv_tot - rv0, 32'd0);
      check("mis we_cnt",  we_tot - we0, 32'd0);
      check("mis exc_cnt", ex_tot - ex0, 32'd1);
      check("mis hold",    bus.resp_data, last_data);
`else
      v = '{4'd4, 32'h13, 32'h0, 5'd9, 32'hDEADBEEF};
      run_req(23, v);
      v = '{4'd2, 32'h27, 32'h0, 5'd16, 32'hFFFF8001};
      run_req(24, v);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
`default_nettype wire
